// File: rtl/track_occupancy_detector.sv
// Axle-counting occupancy detector: synchronised, debounced approach/exit sensors drive
// an IDLE/OCCUPIED/CLEARING/FAULT machine. Define TRACK_DET_TIMEOUT_EN to build the OCCUPIED watchdog.
module track_occupancy_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned CLEAR_HOLD      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_in,
    input  logic             sensor_out,
    input  logic             fault_clear,
    output logic             train_detected,
    output logic [CNT_W-1:0] axle_count,
    output logic             fault
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = (CLEAR_HOLD < 2) ? 1 : $clog2(CLEAR_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLEAR_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, OCCUPIED, CLEARING, FAULT} state_t;

    // Bit 0 carries the approach sensor, bit 1 the exit sensor.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      filt;
    logic [1:0]      filt_d;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state;
    logic [CNT_W-1:0] count;
    logic [HOLD_W-1:0] hold;

    logic enter;
    logic leave;
    logic up;
    logic down;
    logic both_low;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1  <= {sensor_out, sensor_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        enter    = filt[0] & ~filt_d[0];
        leave    = filt[1] & ~filt_d[1];
        up       = enter & ~leave;
        down     = leave & ~enter;
        both_low = ~|filt;
    end

`ifdef TRACK_DET_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            activity;

    // Any filtered level change on either sensor counts as proof of life.
    always_comb activity = |(filt ^ filt_d);
`endif

    // Outputs are registered alongside each state transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= '0;
            hold           <= '0;
            train_detected <= 1'b0;
            fault          <= 1'b0;
`ifdef TRACK_DET_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (up) begin
                        state          <= OCCUPIED;
                        count          <= CNT_ONE;
                        train_detected <= 1'b1;
`ifdef TRACK_DET_TIMEOUT_EN
                        wd_cnt         <= '0;
`endif
                    end else if (down) begin
                        state          <= FAULT;
                        train_detected <= 1'b1;
                        fault          <= 1'b1;
                    end
                end
                OCCUPIED: begin
                    if (up) begin
                        if (count == CNT_MAX) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end else if (down) begin
                        if (count == '0) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            count <= count - CNT_ONE;
                            if (count == CNT_ONE) begin
                                state <= CLEARING;
                                hold  <= HOLD_LOAD;
                            end
                        end
                    end
`ifdef TRACK_DET_TIMEOUT_EN
                    if (activity) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                CLEARING: begin
                    if (up) begin
                        state <= OCCUPIED;
                        count <= CNT_ONE;
`ifdef TRACK_DET_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else if (down) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (hold <= HOLD_W'(1)) begin
                        state          <= IDLE;
                        train_detected <= 1'b0;
                    end else begin
                        hold <= hold - HOLD_W'(1);
                    end
                end
                FAULT: begin
                    if (fault_clear && both_low) begin
                        state          <= IDLE;
                        count          <= '0;
                        train_detected <= 1'b0;
                        fault          <= 1'b0;
                    end else if (up && count != CNT_MAX) begin
                        count <= count + CNT_ONE;
                    end else if (down && count != '0) begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state          <= FAULT;
                    train_detected <= 1'b1;
                    fault          <= 1'b1;
                end
            endcase
        end
    end

    assign axle_count = count;

endmodule

// File: tb/tb_track_occupancy_detector.sv
// Scoreboard bench for track_occupancy_detector: a behavioural model predicts each output
// change (with its clock edge number); a monitor compares every change the DUT presents.
module tb_track_occupancy_detector;

    localparam int unsigned D  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned CH = 8;
    localparam int unsigned T  = 200;
    localparam int MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_in = 1'b0;
    logic sensor_out = 1'b0;
    logic fault_clear = 1'b0;
    logic train_detected;
    logic fault;
    logic [W-1:0] axle_count;

    track_occupancy_detector #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(W),
        .CLEAR_HOLD(CH),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sensor_in(sensor_in),
        .sensor_out(sensor_out),
        .fault_clear(fault_clear),
        .train_detected(train_detected),
        .axle_count(axle_count),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int stamp;
        int cnt;
        bit td;
        bit f;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw sample history, filtered levels, section occupancy.
    localparam int M_IDLE = 0, M_OCC = 1, M_CLR = 2, M_FAULT = 3;
    bit rin [D+2];
    bit rout[D+2];
    bit fi, fip, fo, fop;
    int m_mode, m_cnt, m_hold, m_quiet;
    int last_cnt;
    bit last_td, last_f;

    task automatic push_if_changed(input int stamp);
        exp_t e;
        bit td, f;
        td = (m_mode != M_IDLE);
        f  = (m_mode == M_FAULT);
        if (m_cnt != last_cnt || td != last_td || f != last_f) begin
            e.stamp = stamp; e.cnt = m_cnt; e.td = td; e.f = f;
            sb.push_back(e);
            last_cnt = m_cnt; last_td = td; last_f = f;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < D + 2; k++) begin rin[k] = 0; rout[k] = 0; end
        fi = 0; fip = 0; fo = 0; fop = 0;
        m_mode = M_IDLE; m_cnt = 0; m_hold = 0; m_quiet = 0;
    endtask

    task automatic model_edge(input bit i, input bit o, input bit c);
        bit e, l, act, low, flip_i, flip_o, up, dn;
        for (int k = D + 1; k > 0; k--) begin rin[k] = rin[k-1]; rout[k] = rout[k-1]; end
        rin[0] = i; rout[0] = o;
        e   = fi && !fip;
        l   = fo && !fop;
        act = (fi != fip) || (fo != fop);
        low = !fi && !fo;
        up  = e && !l;
        dn  = l && !e;
        // A filtered level flips once the last D synchronised samples all disagree with it.
        flip_i = 1; flip_o = 1;
        for (int k = 2; k < D + 2; k++) begin
            if (rin[k] == fi)  flip_i = 0;
            if (rout[k] == fo) flip_o = 0;
        end
        fip = fi; fop = fo;
        if (flip_i) fi = !fi;
        if (flip_o) fo = !fo;

        case (m_mode)
            M_IDLE: begin
                if (up) begin m_mode = M_OCC; m_cnt = 1; m_quiet = 0; end
                else if (dn) m_mode = M_FAULT;
            end
            M_OCC: begin
                if (up) begin
                    if (m_cnt == MAXC) m_mode = M_FAULT; else m_cnt++;
                end else if (dn) begin
                    if (m_cnt == 0) m_mode = M_FAULT;
                    else begin
                        m_cnt--;
                        if (m_cnt == 0) begin m_mode = M_CLR; m_hold = CH; end
                    end
                end
`ifdef TRACK_DET_TIMEOUT_EN
                if (act) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == T) m_mode = M_FAULT;
                end
`endif
            end
            M_CLR: begin
                if (up) begin m_mode = M_OCC; m_cnt = 1; m_quiet = 0; end
                else if (dn) m_mode = M_FAULT;
                else if (m_hold <= 1) m_mode = M_IDLE;
                else m_hold--;
            end
            default: begin
                if (c && low) begin m_mode = M_IDLE; m_cnt = 0; end
                else if (up && m_cnt < MAXC) m_cnt++;
                else if (dn && m_cnt > 0) m_cnt--;
            end
        endcase
        push_if_changed(edge_no + 1);
    endtask

    // Monitor: every change of the DUT outputs is one scoreboard transaction.
    logic [W+1:0] last_seen = '0;
    always @(negedge clk) begin
        logic [W+1:0] cur;
        exp_t e;
        cur = {axle_count, train_detected, fault};
        if (cur !== last_seen) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change edge %0d: got cnt=%0d td=%b fault=%b, required no change",
                         edge_no, axle_count, train_detected, fault);
            end else begin
                e = sb.pop_front();
                if (e.stamp != edge_no || axle_count !== W'(e.cnt) ||
                    train_detected !== e.td || fault !== e.f) begin
                    n_bad++;
                    $display("FAIL output_change: got edge=%0d cnt=%0d td=%b fault=%b, required edge=%0d cnt=%0d td=%b fault=%b",
                             edge_no, axle_count, train_detected, fault, e.stamp, e.cnt, e.td, e.f);
                end
            end
            last_seen = cur;
        end
    end

    task automatic check_now(input string name, input int c, input bit td, input bit f);
        n_cmp++;
        if (axle_count !== W'(c) || train_detected !== td || fault !== f) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d td=%b fault=%b, required cnt=%0d td=%b fault=%b",
                     name, axle_count, train_detected, fault, c, td, f);
        end
    endtask

    task automatic step(input bit i, input bit o, input bit c);
        @(negedge clk);
        reset = 1'b1;
        sensor_in = i; sensor_out = o; fault_clear = c;
        @(posedge clk);
        model_edge(i, o, c);
    endtask

    task automatic pulse_in(input int hi, input int lo);
        repeat (hi) step(1, 0, 0);
        repeat (lo) step(0, 0, 0);
    endtask

    task automatic pulse_out(input int hi, input int lo);
        repeat (hi) step(0, 1, 0);
        repeat (lo) step(0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        bit ci, co, cc;
        int ti, to;
        model_clear();
        last_cnt = 0; last_td = 0; last_f = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_now("reset_state", 0, 0, 0);

        // Glitch shorter than the debounce window.
        repeat (3) step(1, 0, 0);
        repeat (15) step(0, 0, 0);
        check_now("glitch", 0, 0, 0);

        // Normal passage, with the first-detection latency checked directly.
        repeat (6) step(1, 0, 0);
        #1 check_now("latency_minus1", 0, 0, 0);
        step(1, 0, 0);
        #1 check_now("latency", 1, 1, 0);
        repeat (3) step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        repeat (3) pulse_in(10, 10);
        repeat (4) pulse_out(10, 10);
        repeat (20) step(0, 0, 0);

        // Re-entry three cycles into the clearing hold.
        pulse_in(10, 10);
        repeat (3) step(0, 1, 0);
        repeat (7) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        #1 check_now("reentry", 1, 1, 0);
        pulse_out(10, 30);

        // Underflow from IDLE, then recovery.
        pulse_out(10, 10);
        #1 check_now("underflow", 0, 1, 1);
        step(0, 0, 1);
        #1 check_now("fault_clear", 0, 0, 0);
        step(0, 0, 0);

        // Stuck occupancy with the approach sensor held high.
        repeat (250) step(1, 0, 0);
`ifdef TRACK_DET_TIMEOUT_EN
        #1 check_now("stuck", 1, 1, 1);
        step(1, 0, 1);
        #1 check_now("clear_ignored", 1, 1, 1);
`else
        #1 check_now("stuck", 1, 1, 0);
        step(1, 0, 1);
        #1 check_now("clear_ignored", 1, 1, 0);
`endif
        repeat (20) step(0, 0, 0);
        step(0, 0, 1);
        pulse_out(10, 30);
        step(0, 0, 1);
        step(0, 0, 0);
        #1 check_now("stuck_end", 0, 0, 0);

        // Overflow: one axle more than the counter can hold.
        repeat (MAXC + 1) pulse_in(5, 5);
        #1 check_now("overflow", MAXC, 1, 1);
        repeat (10) step(0, 0, 0);
        step(0, 0, 1);
        #1 check_now("overflow_clear", 0, 0, 0);

        // Asynchronous reset between clock edges with two axles inside.
        repeat (2) pulse_in(10, 10);
        #1 check_now("two_axles", 2, 1, 0);
        #1 reset = 1'b0;
        model_clear();
        push_if_changed(edge_no);
        #1 check_now("async_reset", 0, 0, 0);
        repeat (3) @(negedge clk);
        pulse_out(10, 10);
        #1 check_now("post_reset_underflow", 0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Randomised sensor traffic with occasional clear requests.
        ci = 0; co = 0; ti = 0; to = 0;
        repeat (3000) begin
            if (ti == 0) begin ci = !ci; ti = $urandom_range(1, 14); end
            if (to == 0) begin co = !co; to = $urandom_range(1, 14); end
            cc = ($urandom_range(0, 39) == 0);
            step(ci, co, cc);
            ti--; to--;
        end
        repeat (40) step(0, 0, 0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected changes, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/track_occupancy_detector.md
# track_occupancy_detector

Upstream stage of `rail_track_crossing`: turns two raw trackside axle sensors into the clean `train_detected` level that the crossing controller consumes. Both sensors are synchronised and debounced. Axles are counted in at the approach sensor and out at the exit sensor. `train_detected` is held high while any axle remains in the section, and for a short hold-off after the count returns to zero. Under/overflow and a stuck-occupancy watchdog force a fail-safe fault state that keeps `train_detected` asserted.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before a filtered sensor level changes (≥1).
- `CNT_W`, 8: width of the axle counter.
- `CLEAR_HOLD`, 8: cycles `train_detected` stays high after the count reaches 0.
- `TIMEOUT_CYCLES`, 1000: maximum cycles in OCCUPIED with no filtered sensor edge.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `sensor_in`  input  1  raw approach sensor; high while an axle is over it; asynchronous to `clk`.
- `sensor_out`  input  1  raw exit sensor; same semantics.
- `fault_clear`  input  1  synchronous single-cycle request to leave FAULT.
- `train_detected`  output  1  section occupied or fail-safe; feeds `rail_track_crossing.train_detected`.
- `axle_count`  output  CNT_W  axles currently inside the section.
- `fault`  output  1  high while in FAULT.

## Operation
- Each raw sensor passes through a 2-flop synchroniser, then a debounce counter.
  - The filtered level takes the new value after `DEBOUNCE_CYCLES` consecutive synchronised samples differ from it.
  - Any sample equal to the current filtered level resets the counter.
- A rising edge of filtered in is an axle entering; a rising edge of filtered out is an axle leaving. Falling edges are ignored.
- Counter rules:
  - Enter only: +1. Leave only: −1. Both in the same cycle: no change.
  - Enter at all-ones: count saturates and the block goes to FAULT.
  - Leave at 0: count stays 0 and the block goes to FAULT.
- State machine, with states IDLE, OCCUPIED, CLEARING and FAULT:
  - IDLE: `train_detected`=0. An enter edge moves to OCCUPIED with count=1.
  - OCCUPIED: `train_detected`=1.
    - Count reaching 0 moves to CLEARING and loads the hold counter with `CLEAR_HOLD`.
    - No filtered edge for `TIMEOUT_CYCLES` moves to FAULT. The watchdog restarts on every filtered edge.
  - CLEARING: `train_detected`=1.
    - An enter edge returns to OCCUPIED (count=1).
    - A leave edge moves to FAULT (underflow).
    - Hold counter expiry moves to IDLE.
  - FAULT: `train_detected`=1, `fault`=1. Edges still update the count, with saturation at both ends.
    - `fault_clear` is honoured only when both filtered levels are 0.
    - When honoured: count←0 and state←IDLE.
    - Otherwise `fault_clear` is ignored.
- A `fault_clear` pulse in any state other than FAULT has no effect.

## Timing
- Reset values, applied immediately on `reset` low:
  - state IDLE; `train_detected`=0, `axle_count`=0, `fault`=0.
  - Synchronisers, filtered levels, debounce, hold and watchdog counters all 0.
- Reset mid-train: the section is forgotten. After release, residual exit edges cause an underflow FAULT. This fail-safe behaviour is intended.
- Latency from a raw sensor change held stable to the `axle_count`/`train_detected` update is 2 (sync) + `DEBOUNCE_CYCLES` + 1 clock edges, i.e. 7 at defaults.
- State and counter updates are registered. `train_detected` and `fault` are decoded from registered state, so they are glitch-free.
- CLEARING→IDLE: `train_detected` falls exactly `CLEAR_HOLD` cycles after the cycle `axle_count` becomes 0.
- Timeout: FAULT is entered on the `TIMEOUT_CYCLES`-th consecutive edge-free cycle in OCCUPIED.
- `fault_clear` is sampled on the rising edge. IDLE takes effect on the following cycle.

## Configuration
- `TRACK_DET_TIMEOUT_EN`:
  - Defined: the OCCUPIED watchdog and its counter are built as described.
  - Undefined: no watchdog logic. OCCUPIED persists indefinitely, and FAULT is entered only on overflow or underflow.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `CLEAR_HOLD`=8, `TIMEOUT_CYCLES`=200.
- Glitch rejection: `sensor_in` high for 3 cycles → `axle_count` stays 0 and `train_detected` stays 0.
- Normal passage: 4 axle pulses on `sensor_in` (each 10 cycles high, 10 low), then 4 on `sensor_out`.
  - `axle_count` goes 1,2,3,4,3,2,1,0.
  - `train_detected` rises 7 cycles after the first `sensor_in` rise and falls 8 cycles after the count reaches 0.
- Re-entry during CLEARING: enter/leave one axle, then an enter edge 3 cycles into the hold → state OCCUPIED, count=1, `train_detected` never drops.
- Underflow: `sensor_out` pulse from IDLE → `fault`=1, `train_detected`=1, count=0.
  - `fault_clear` with both sensors low → IDLE on the next cycle, both outputs 0.
- Stuck occupancy (macro defined): one enter edge, then no activity → `fault`=1 after 200 edge-free cycles.
  - `fault_clear` while `sensor_in` is held high → ignored.
- Async reset mid-passage: count=2, pull `reset` low between clock edges → all outputs 0 immediately.
  - Subsequent exit edges after release → FAULT.
